// File: rtl/greater_sweeper.sv
// Operand sequencer that walks every {a, b} combination through an external
// comparator, records its truth table and scores it against an a > b model.
module greater_sweeper #(
    parameter int WIDTH = 2,
    parameter int DWELL = 4,
    localparam int N = 2 ** (2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    input  logic                 f,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         result_table,
    output logic [2*WIDTH:0]     ones_count,
    output logic [2*WIDTH:0]     err_count,
    output logic [2*WIDTH-1:0]   first_err
);

    localparam int IW = 2 * WIDTH;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;

    // Reference result for the pair currently on the operand bus.
    function automatic logic golden(input logic [IW-1:0] i);
        return (i[IW-1:WIDTH] > i[WIDTH-1:0]);
    endfunction

    // The index register is the operand bus itself, so a and b are registered.
    assign a = idx[IW-1:WIDTH];
    assign b = idx[WIDTH-1:0];

    // Sweep sequencer, sampling and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_table <= '0;
            ones_count   <= '0;
            err_count    <= '0;
            first_err    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state        <= DRIVE;
                        busy         <= 1'b1;
                        idx          <= '0;
                        cnt          <= '0;
                        result_table <= '0;
                        ones_count   <= '0;
                        err_count    <= '0;
                        first_err    <= '0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (cnt == LAST_CNT) begin
                        result_table[idx] <= f;
                        if (f) begin
                            ones_count <= ones_count + (IW+1)'(1);
                        end
                        // Only the earliest mismatch is remembered.
                        if (f != golden(idx)) begin
                            err_count <= err_count + (IW+1)'(1);
                            if (err_count == '0) begin
                                first_err <= idx;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                            cnt <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
